packet_buffer_write_arbiter: RTL
================================

PACKET_BUFFER_WRITE_ARBITER -- requirements
Module: packet_buffer_write_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_PORTS, default 4, meaning the number of ingress requesters (2..16).
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, meaning the payload beat width; it is fixed at 32, equal to the header width.
REQ-003 The block SHALL have parameter MAX_PACKET_LENGTH, default 1500, meaning the largest legal packet length in bytes.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 in_valid  input  NUM_PORTS  per-port beat valid.
REQ-008 in_data  input  NUM_PORTS*32  per-port beat data, where port p occupies [32p+31:32p].
REQ-009 in_last  input  NUM_PORTS  per-port last beat of packet.
REQ-010 in_len  input  NUM_PORTS*16  per-port packet length in bytes, held stable from the first beat through the last beat.
REQ-011 in_ready  output  NUM_PORTS  per-port beat accept.
REQ-012 out_valid  output  1  buffer write-port valid.
REQ-013 out_data  output  32  buffer write-port data.
REQ-014 out_last  output  1  last word of the record.
REQ-015 out_ready  input  1  buffer write-port accept.
REQ-016 pkt_count  output  32  packets forwarded; saturates at all-ones.
REQ-017 drop_count  output  16  packets dropped; saturates at all-ones.

Function
REQ-018 Each forwarded record SHALL consist of one header word followed by the packet's payload beats.
- Header word layout: bits [15:0] = packet_length (in_len of the granted port); bits [31:16] = interface_id (granted port index, zero-extended).
REQ-019 The FSM SHALL have the states IDLE, HDR, PAYLOAD and DROP.
REQ-020 In IDLE, if any in_valid is 1, the block SHALL register a grant g, chosen round-robin starting from the port after the last granted port, and move to HDR on the next cycle.
- After reset the search starts at port 0.
- No in_ready is asserted in IDLE.
REQ-021 In HDR, if in_len[g] is 0 or greater than MAX_PACKET_LENGTH, the block SHALL go to DROP without asserting out_valid.
- Otherwise it drives out_valid=1, out_data=header and out_last=0.
- On out_valid and out_ready it moves to PAYLOAD.
- The header is held stable while out_ready is 0.
REQ-022 In PAYLOAD, the block SHALL connect port g combinationally to the output and hold all other in_ready at 0.
- out_valid = in_valid[g]
- out_data = in_data[g]
- out_last = in_last[g]
- in_ready[g] = out_ready
REQ-023 In PAYLOAD, a handshake with in_last[g]=1 SHALL increment pkt_count and return the FSM to IDLE.
REQ-024 In DROP, the block SHALL assert in_ready[g]=1 and out_valid=0, consuming beats; a handshake with in_last[g]=1 SHALL increment drop_count and return the FSM to IDLE.
REQ-025 Latency SHALL be one cycle from in_valid rising in IDLE to the header on out_valid.
- There is exactly one idle bubble cycle between consecutive records.
REQ-026 The grant SHALL change only in IDLE; a packet is never interleaved with another port's packet.
REQ-027 The round-robin pointer SHALL advance on every grant, including grants that end in DROP.
REQ-028 A port that drops in_valid mid-packet SHALL stall the output (out_valid=0) without releasing the grant.
REQ-029 Single-beat packets (in_last on the first beat) SHALL produce a two-word record: header plus one payload word, with out_last on the payload word.
REQ-030 Counter increments SHALL saturate and never wrap.

Reset
REQ-031 While rst_n=0, the block SHALL immediately force all of the following, asynchronously:
- FSM to IDLE, round-robin pointer to 0
- out_valid=0, out_last=0, out_data=0, in_ready=0
- pkt_count=0, drop_count=0
REQ-032 A reset asserted mid-record SHALL abandon the record with no further output beats; after rst_n deasserts, operation resumes from IDLE on the next rising edge.

Verification
REQ-033 Port 2 sends in_len=8, two beats A,B -> output sequence 0x0002_0008, A, B with out_last on B; pkt_count=1.
REQ-034 All four ports valid simultaneously, one beat each, in_len=4 -> records are granted in port order 0,1,2,3, then 0 again.
REQ-035 Port 1 sends in_len=0 or in_len=1501 with three beats -> no out_valid, in_ready[1] is high for 3 beats, drop_count=1; in_len=1500 -> forwarded.
REQ-036 out_ready is held low for 5 cycles during HDR and during PAYLOAD -> header and data remain stable, no beat is lost or duplicated, and in_ready[g] tracks out_ready.
REQ-037 rst_n is pulsed low in the middle of PAYLOAD -> out_valid drops in the same cycle and both counters read 0; the next packet from port 0 is output with the correct header.
REQ-038 pkt_count preloaded to 0xFFFF_FFFF via force, then one more packet forwarded -> pkt_count stays at 0xFFFF_FFFF.

Source files
------------

// File: rtl/packet_buffer_write_arbiter.sv
// -----------------------------------------------------------------------------
// packet_buffer_write_arbiter
//
// Purpose:
//   Round-robin arbiter that merges packets from NUM_PORTS ingress requesters
//   onto a single packet-buffer write port. Each forwarded packet becomes a
//   record: one header word {interface_id[15:0], packet_length[15:0]} followed
//   by the packet's payload beats. Packets whose length is zero or larger than
//   MAX_PACKET_LENGTH are consumed from the ingress port and discarded.
//
// Ports:
//   clk, rst_n     - rising-edge clock, asynchronous active-low reset
//   in_valid[p]    - beat valid for ingress port p
//   in_data        - beat data, port p at [32p+31:32p]
//   in_last[p]     - last beat of the packet on port p
//   in_len         - packet length in bytes, port p at [16p+15:16p]
//   in_ready[p]    - beat accept for ingress port p
//   out_valid/out_data/out_last/out_ready - buffer write port
//   pkt_count      - packets forwarded (saturating)
//   drop_count     - packets dropped (saturating)
// -----------------------------------------------------------------------------
module packet_buffer_write_arbiter #(
    parameter int NUM_PORTS         = 4,
    parameter int DATA_WIDTH        = 32,
    parameter int MAX_PACKET_LENGTH = 1500
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_PORTS-1:0]            in_valid,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_PORTS-1:0]            in_last,
    input  logic [NUM_PORTS*16-1:0]         in_len,
    output logic [NUM_PORTS-1:0]            in_ready,
    output logic                            out_valid,
    output logic [DATA_WIDTH-1:0]           out_data,
    output logic                            out_last,
    input  logic                            out_ready,
    output logic [31:0]                     pkt_count,
    output logic [15:0]                     drop_count
);

    localparam int IDX_W = $clog2(NUM_PORTS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HDR     = 2'd1,
        PAYLOAD = 2'd2,
        DROP    = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic [IDX_W-1:0]        r_grant;
    logic [IDX_W-1:0]        r_rr_ptr;
    logic [IDX_W-1:0]        w_pick;
    logic [IDX_W-1:0]        w_ptr_next;
    logic                    w_found;
    logic [NUM_PORTS-1:0]    w_grant_oh;
    logic                    w_g_valid;
    logic                    w_g_last;
    logic [DATA_WIDTH-1:0]   w_g_data;
    logic [15:0]             w_len;
    logic                    w_len_bad;
    logic                    w_pkt_done;
    logic                    w_drop_done;
    logic [31:0]             r_pkt_count;
    logic [15:0]             r_drop_count;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Round-robin search: the first valid port at or after r_rr_ptr wins.
    // Every index is a constant after unrolling, so no variable bit-selects.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (r_rr_ptr == IDX_W'(p)) begin
                for (int i = NUM_PORTS - 1; i >= 0; i--) begin
                    if (in_valid[(p + i) % NUM_PORTS]) begin
                        w_found = 1'b1;
                        w_pick  = IDX_W'((p + i) % NUM_PORTS);
                    end
                end
            end
        end
    end

    // Pointer moves to the port after the one just granted, wrapping.
    always_comb begin
        w_ptr_next = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (w_pick == IDX_W'(p)) begin
                w_ptr_next = IDX_W'((p + 1) % NUM_PORTS);
            end
        end
    end

    // Select the granted port's signals.
    always_comb begin
        w_grant_oh = '0;
        w_g_valid  = 1'b0;
        w_g_last   = 1'b0;
        w_g_data   = '0;
        w_len      = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (r_grant == IDX_W'(p)) begin
                w_grant_oh[p] = 1'b1;
                w_g_valid     = in_valid[p];
                w_g_last      = in_last[p];
                w_g_data      = in_data[p*DATA_WIDTH +: DATA_WIDTH];
                w_len         = in_len[p*16 +: 16];
            end
        end
    end

    assign w_len_bad = (w_len == 16'd0) || (32'(w_len) > 32'(MAX_PACKET_LENGTH));

    always_comb begin
        w_next_state = r_state;
        out_valid    = 1'b0;
        out_data     = '0;
        out_last     = 1'b0;
        in_ready     = '0;
        w_pkt_done   = 1'b0;
        w_drop_done  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_next_state = HDR;
                end
            end
            HDR: begin
                if (w_len_bad) begin
                    w_next_state = DROP;
                end else begin
                    out_valid = 1'b1;
                    out_data  = {16'(r_grant), w_len};
                    if (out_ready) begin
                        w_next_state = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                // Granted port is wired straight through; a stalled port
                // simply shows out_valid=0 while keeping the grant.
                out_valid = w_g_valid;
                out_data  = w_g_data;
                out_last  = w_g_last;
                in_ready  = w_grant_oh & {NUM_PORTS{out_ready}};
                if (w_g_valid && out_ready && w_g_last) begin
                    w_pkt_done   = 1'b1;
                    w_next_state = IDLE;
                end
            end
            DROP: begin
                // Drain the rejected packet without touching the output.
                in_ready = w_grant_oh;
                if (w_g_valid && w_g_last) begin
                    w_drop_done  = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_grant      <= '0;
            r_rr_ptr     <= '0;
            r_pkt_count  <= '0;
            r_drop_count <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == IDLE && w_found) begin
                r_grant  <= w_pick;
                r_rr_ptr <= w_ptr_next;
            end
            if (w_pkt_done) begin
                r_pkt_count <= sat_inc32(r_pkt_count);
            end
            if (w_drop_done) begin
                r_drop_count <= sat_inc16(r_drop_count);
            end
        end
    end

    assign pkt_count  = r_pkt_count;
    assign drop_count = r_drop_count;

endmodule
